// File: rtl/sc_regbank_pkg.sv
// Shared definitions for the accumulating register bank: the operation encodings
// used by the write port.
package sc_regbank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

endpackage

// File: rtl/sc_satadd.sv
// Signed add/subtract with overflow detect; on overflow either clamps to the
// signed extreme or keeps the low bits, selected by SATURATE.
module sc_satadd #(
  parameter int DATAWIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sub,
  output logic [DATAWIDTH-1:0] result,
  output logic                 ovf
);

  logic [DATAWIDTH:0] ext_a;
  logic [DATAWIDTH:0] ext_b;
  logic [DATAWIDTH:0] sum;

  always_comb begin
    ext_a  = {a[DATAWIDTH-1], a};
    ext_b  = {b[DATAWIDTH-1], b};
    sum    = sub ? (ext_a - ext_b) : (ext_a + ext_b);
    // The extra sign bit disagrees with the DATAWIDTH sign bit exactly when the
    // true result does not fit.
    ovf    = sum[DATAWIDTH] ^ sum[DATAWIDTH-1];
    result = sum[DATAWIDTH-1:0];
    if ((SATURATE != 0) && ovf) begin
      result = sum[DATAWIDTH] ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                              : {1'b0, {(DATAWIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sc_regbank_acc.sv
// Multi-channel accumulating register bank with a shadow bank captured on commit
// and a per-channel sticky overflow flag.
module sc_regbank_acc
  import sc_regbank_pkg::*;
#(
  parameter int DATAWIDTH     = 32,
  parameter int CHANNELS      = 4,
  parameter int INITIAL_VALUE = 0,
  parameter int SATURATE      = 1,
  localparam int CHSEL        = $clog2(CHANNELS)
) (
  input  logic                 SC_REGBANK_ACC_CLOCK_50,
  input  logic                 SC_REGBANK_ACC_RESET_InLow,
  input  logic                 SC_REGBANK_ACC_clear_InLow,
  input  logic                 SC_REGBANK_ACC_write_InLow,
  input  logic [1:0]           SC_REGBANK_ACC_op_InBUS,
  input  logic [CHSEL-1:0]     SC_REGBANK_ACC_chsel_InBUS,
  input  logic [DATAWIDTH-1:0] SC_REGBANK_ACC_data_InBUS,
  input  logic                 SC_REGBANK_ACC_commit_InLow,
  input  logic [CHSEL-1:0]     SC_REGBANK_ACC_rdsel_InBUS,
  output logic [DATAWIDTH-1:0] SC_REGBANK_ACC_data_OutBUS,
  output logic [CHANNELS-1:0]  SC_REGBANK_ACC_ovf_OutBUS,
  output logic                 SC_REGBANK_ACC_ack_OutHigh
);

  localparam logic [DATAWIDTH-1:0] INIT = DATAWIDTH'(INITIAL_VALUE);

  logic [DATAWIDTH-1:0] working [CHANNELS];
  logic [DATAWIDTH-1:0] shadow  [CHANNELS];
  logic [CHANNELS-1:0]  ovf;
  logic                 ack;

  logic [DATAWIDTH-1:0] alu_result;
  logic                 alu_ovf;
  op_t                  op;

  assign op = op_t'(SC_REGBANK_ACC_op_InBUS);

  sc_satadd #(
    .DATAWIDTH (DATAWIDTH),
    .SATURATE  (SATURATE)
  ) u_satadd (
    .a      (working[SC_REGBANK_ACC_chsel_InBUS]),
    .b      (SC_REGBANK_ACC_data_InBUS),
    .sub    (op == OP_SUB),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  // Write handshake: a write is accepted on any edge where write_InLow is low,
  // clear_InLow is high and reset is released; there is no back-pressure, and
  // ack_OutHigh is high for exactly the cycle following each accepted write.
  always_ff @(posedge SC_REGBANK_ACC_CLOCK_50) begin
    if (!SC_REGBANK_ACC_RESET_InLow) begin
      for (int i = 0; i < CHANNELS; i++) begin
        working[i] <= INIT;
        shadow[i]  <= INIT;
      end
      ovf <= '0;
      ack <= 1'b0;
    end else begin
      ack <= 1'b0;
      // Commit samples pre-edge working values, so it is unaffected by a
      // clear or write on the same edge.
      if (!SC_REGBANK_ACC_commit_InLow) begin
        for (int i = 0; i < CHANNELS; i++) shadow[i] <= working[i];
      end
      if (!SC_REGBANK_ACC_clear_InLow) begin
        for (int i = 0; i < CHANNELS; i++) working[i] <= INIT;
        ovf <= '0;
      end else if (!SC_REGBANK_ACC_write_InLow) begin
        ack <= 1'b1;
        case (op)
          OP_LOAD: begin
            working[SC_REGBANK_ACC_chsel_InBUS] <= SC_REGBANK_ACC_data_InBUS;
            ovf[SC_REGBANK_ACC_chsel_InBUS]     <= 1'b0;
          end
          OP_ADD, OP_SUB: begin
            working[SC_REGBANK_ACC_chsel_InBUS] <= alu_result;
            if (alu_ovf) ovf[SC_REGBANK_ACC_chsel_InBUS] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign SC_REGBANK_ACC_data_OutBUS = shadow[SC_REGBANK_ACC_rdsel_InBUS];
  assign SC_REGBANK_ACC_ovf_OutBUS  = ovf;
  assign SC_REGBANK_ACC_ack_OutHigh = ack;

endmodule

// File: tb/tb_sc_regbank_acc.sv
// Bench for sc_regbank_acc: a saturating and a wrapping instance share inputs;
// table-driven vectors plus hand-written commit/clear/reset sequences.
module tb_sc_regbank_acc;
  import sc_regbank_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clear_n;
  logic       write_n;
  logic [1:0] op;
  logic [1:0] chsel;
  logic [7:0] din;
  logic       commit_n;
  logic [1:0] rdsel;
  logic [7:0] dout_s, dout_w;
  logic [3:0] ovf_s, ovf_w;
  logic       ack_s, ack_w;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    op_t        op;
    logic [1:0] ch;
    logic [7:0] data;
    logic [3:0] ovf;
    logic [7:0] dsat;
    logic [7:0] dwrap;
  } vec_t;

  vec_t vecs[12];

  sc_regbank_acc #(.DATAWIDTH(8), .CHANNELS(4), .INITIAL_VALUE(0), .SATURATE(1)) dut_sat (
    .SC_REGBANK_ACC_CLOCK_50     (clk),
    .SC_REGBANK_ACC_RESET_InLow  (rst_n),
    .SC_REGBANK_ACC_clear_InLow  (clear_n),
    .SC_REGBANK_ACC_write_InLow  (write_n),
    .SC_REGBANK_ACC_op_InBUS     (op),
    .SC_REGBANK_ACC_chsel_InBUS  (chsel),
    .SC_REGBANK_ACC_data_InBUS   (din),
    .SC_REGBANK_ACC_commit_InLow (commit_n),
    .SC_REGBANK_ACC_rdsel_InBUS  (rdsel),
    .SC_REGBANK_ACC_data_OutBUS  (dout_s),
    .SC_REGBANK_ACC_ovf_OutBUS   (ovf_s),
    .SC_REGBANK_ACC_ack_OutHigh  (ack_s)
  );

  sc_regbank_acc #(.DATAWIDTH(8), .CHANNELS(4), .INITIAL_VALUE(0), .SATURATE(0)) dut_wrap (
    .SC_REGBANK_ACC_CLOCK_50     (clk),
    .SC_REGBANK_ACC_RESET_InLow  (rst_n),
    .SC_REGBANK_ACC_clear_InLow  (clear_n),
    .SC_REGBANK_ACC_write_InLow  (write_n),
    .SC_REGBANK_ACC_op_InBUS     (op),
    .SC_REGBANK_ACC_chsel_InBUS  (chsel),
    .SC_REGBANK_ACC_data_InBUS   (din),
    .SC_REGBANK_ACC_commit_InLow (commit_n),
    .SC_REGBANK_ACC_rdsel_InBUS  (rdsel),
    .SC_REGBANK_ACC_data_OutBUS  (dout_w),
    .SC_REGBANK_ACC_ovf_OutBUS   (ovf_w),
    .SC_REGBANK_ACC_ack_OutHigh  (ack_w)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic write_op(input logic [1:0] o, input logic [1:0] ch, input logic [7:0] d);
    write_n = 1'b0;
    op      = o;
    chsel   = ch;
    din     = d;
    tick();
    write_n = 1'b1;
    op      = OP_HOLD;
  endtask

  task automatic do_commit();
    commit_n = 1'b0;
    tick();
    commit_n = 1'b1;
  endtask

  task automatic read_sat(input string name, input logic [1:0] ch, input logic [7:0] exp);
    rdsel = ch;
    #1;
    check(name, {24'h0, dout_s}, {24'h0, exp});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [23:0] exp_rec;
    logic [23:0] got;

    rst_n = 1'b0; clear_n = 1'b1; write_n = 1'b1; op = OP_HOLD;
    chsel = 2'd0; din = 8'h00; commit_n = 1'b1; rdsel = 2'd0;

    // Expected values worked by hand for 8-bit signed arithmetic
    vecs[0]  = '{OP_LOAD, 2'd2, 8'h10, 4'b0000, 8'h10, 8'h10};
    vecs[1]  = '{OP_LOAD, 2'd1, 8'h70, 4'b0000, 8'h70, 8'h70};
    vecs[2]  = '{OP_ADD,  2'd1, 8'h20, 4'b0010, 8'h7F, 8'h90};
    vecs[3]  = '{OP_LOAD, 2'd1, 8'h05, 4'b0000, 8'h05, 8'h05};
    vecs[4]  = '{OP_SUB,  2'd1, 8'h0A, 4'b0000, 8'hFB, 8'hFB};
    vecs[5]  = '{OP_ADD,  2'd3, 8'h80, 4'b0000, 8'h80, 8'h80};
    vecs[6]  = '{OP_SUB,  2'd3, 8'h01, 4'b1000, 8'h80, 8'h7F};
    vecs[7]  = '{OP_HOLD, 2'd3, 8'h55, 4'b1000, 8'h80, 8'h7F};
    vecs[8]  = '{OP_ADD,  2'd0, 8'h7F, 4'b1000, 8'h7F, 8'h7F};
    vecs[9]  = '{OP_ADD,  2'd0, 8'h01, 4'b1001, 8'h7F, 8'h80};
    vecs[10] = '{OP_ADD,  2'd0, 8'h81, 4'b1001, 8'h00, 8'h01};
    vecs[11] = '{OP_LOAD, 2'd3, 8'h22, 4'b0001, 8'h22, 8'h22};

    apply_reset();

    // Reset state
    check("rst_ack", {30'h0, ack_s, ack_w}, 32'h0);
    check("rst_ovf", {24'h0, ovf_s, ovf_w}, 32'h0);
    for (int c = 0; c < 4; c++) read_sat("rst_dout", c[1:0], 8'h00);

    // Load, ack one cycle later, commit, read back
    write_op(OP_LOAD, 2'd2, 8'h10);
    check("load_ack", {31'h0, ack_s}, 32'h1);
    tick();
    check("ack_drop", {31'h0, ack_s}, 32'h0);
    read_sat("pre_commit_ch2", 2'd2, 8'h00);
    do_commit();
    read_sat("commit_ch2", 2'd2, 8'h10);
    read_sat("commit_ch0", 2'd0, 8'h00);
    read_sat("commit_ch1", 2'd1, 8'h00);
    read_sat("commit_ch3", 2'd3, 8'h00);

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({vecs[i].ovf, vecs[i].dsat, vecs[i].ovf, vecs[i].dwrap});
      write_op(vecs[i].op, vecs[i].ch, vecs[i].data);
      check($sformatf("vec%0d_ack", i), {30'h0, ack_s, ack_w}, 32'h3);
      do_commit();
      rdsel = vecs[i].ch;
      #1;
      got = {ovf_s, dout_s, ovf_w, dout_w};
      exp_rec = exp_q.pop_front();
      check($sformatf("vec%0d_out", i), {8'h0, got}, {8'h0, exp_rec});
    end

    // Write and commit on the same edge
    apply_reset();
    commit_n = 1'b0;
    write_op(OP_LOAD, 2'd3, 8'h22);
    commit_n = 1'b1;
    read_sat("same_edge_commit", 2'd3, 8'h00);
    do_commit();
    read_sat("next_commit", 2'd3, 8'h22);

    // Clear with commit and a write on the same edge
    write_op(OP_LOAD, 2'd0, 8'h33);
    write_op(OP_LOAD, 2'd2, 8'h7F);
    write_op(OP_ADD, 2'd2, 8'h01);
    do_commit();
    check("pre_clear_ovf", {28'h0, ovf_s}, 32'h4);
    clear_n  = 1'b0;
    commit_n = 1'b0;
    write_op(OP_LOAD, 2'd1, 8'h55);
    clear_n  = 1'b1;
    commit_n = 1'b1;
    check("clear_ack", {31'h0, ack_s}, 32'h0);
    check("clear_ovf", {28'h0, ovf_s}, 32'h0);
    read_sat("clear_shadow0", 2'd0, 8'h33);
    do_commit();
    read_sat("clear_working0", 2'd0, 8'h00);
    read_sat("clear_working1", 2'd1, 8'h00);

    // Reset in the middle of back-to-back adds
    write_n = 1'b0; op = OP_ADD; chsel = 2'd1; din = 8'h01;
    tick();
    check("b2b_ack0", {31'h0, ack_s}, 32'h1);
    tick();
    check("b2b_ack1", {31'h0, ack_s}, 32'h1);
    rst_n = 1'b0;
    commit_n = 1'b0;
    tick();
    rst_n = 1'b1;
    commit_n = 1'b1;
    write_n = 1'b1; op = OP_HOLD;
    check("mid_rst_ack", {31'h0, ack_s}, 32'h0);
    check("mid_rst_ovf", {28'h0, ovf_s}, 32'h0);
    read_sat("mid_rst_dout", 2'd1, 8'h00);
    do_commit();
    read_sat("mid_rst_working", 2'd1, 8'h00);
    write_op(OP_LOAD, 2'd1, 8'h09);
    check("post_rst_ack", {31'h0, ack_s}, 32'h1);
    do_commit();
    read_sat("post_rst_load", 2'd1, 8'h09);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
